// File: rtl/cpu_pkg.sv
// Shared datapath types for the 8-bit CPU: operand/result width, register index width
// and the packed status-flag pair.
package cpu_pkg;

  localparam int DATA_BITS     = 8;
  localparam int REG_ADDR_BITS = 4;

  typedef logic [DATA_BITS-1:0]     data_t;
  typedef logic [REG_ADDR_BITS-1:0] reg_addr_t;

  typedef struct packed {
    logic carry;
    logic zero;
  } flags_t;

endpackage

// File: rtl/status_flags.sv
// Carry/zero status flops captured from the ALU; loaded only when flags_we is high,
// cleared asynchronously by reset.
module status_flags
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   flags_we,
  input  flags_t flags_next,
  output flags_t flags
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else if (flags_we) begin
      flags <= flags_next;
    end
  end

endmodule

// File: rtl/reg_file_flags.sv
// Architectural register file (two combinational read ports, one write port) plus status flags.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto a matching read port.
module reg_file_flags
  import cpu_pkg::*;
#(
  parameter int DATA_BITS = cpu_pkg::DATA_BITS,
  parameter int ADDR_BITS = cpu_pkg::REG_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] rd_addr_a,
  input  logic [ADDR_BITS-1:0] rd_addr_b,
  output logic [DATA_BITS-1:0] rd_data_a,
  output logic [DATA_BITS-1:0] rd_data_b,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 flags_we,
  input  logic                 carry_in,
  input  logic                 zero_in,
  output logic                 carry_flag,
  output logic                 zero_flag
);

  localparam int NUM_REGS = 2 ** ADDR_BITS;

  logic [DATA_BITS-1:0] regs [NUM_REGS];
  logic [DATA_BITS-1:0] stored_a;
  logic [DATA_BITS-1:0] stored_b;
  flags_t               flags_next;
  flags_t               flags;

  // Register 0 is an ordinary register; nothing is hardwired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign stored_a = regs[rd_addr_a];
  assign stored_b = regs[rd_addr_b];

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_data_a = stored_a;
    rd_data_b = stored_b;
    if (wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
  end
`else
  // Same-cycle write to the read address shows the old value until the edge.
  assign rd_data_a = stored_a;
  assign rd_data_b = stored_b;
`endif

  assign flags_next.carry = carry_in;
  assign flags_next.zero  = zero_in;

  status_flags u_status_flags (
    .clk       (clk),
    .reset     (reset),
    .flags_we  (flags_we),
    .flags_next(flags_next),
    .flags     (flags)
  );

  assign carry_flag = flags.carry;
  assign zero_flag  = flags.zero;

endmodule

// File: tb/tb_reg_file_flags.sv
// Self-checking bench for reg_file_flags: directed vector table, hand-written corner
// sequences and randomized cycles against an array-based reference model.
module tb_reg_file_flags;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [7:0] rd_data_a, rd_data_b, wr_data;
  logic       wr_en, flags_we, carry_in, zero_in;
  logic       carry_flag, zero_flag;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_mem [16];
  logic       model_c, model_z;

  reg_file_flags dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .flags_we  (flags_we),
    .carry_in  (carry_in),
    .zero_in   (zero_in),
    .carry_flag(carry_flag),
    .zero_flag (zero_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       fwe;
    logic       c;
    logic       z;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_c;
    logic       exp_z;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_c = 1'b0;
    model_z = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic fwe, input logic c, input logic z);
    wr_en = we; wr_addr = wa; wr_data = wd;
    flags_we = fwe; carry_in = c; zero_in = z;
  endtask

  // Wait for the edge with the current inputs, update the model, then idle the enables.
  task automatic edge_and_idle();
    @(posedge clk);
    if (wr_en) model_mem[wr_addr] = wr_data;
    if (flags_we) begin
      model_c = carry_in;
      model_z = zero_in;
    end
    #1;
    wr_en = 1'b0;
    flags_we = 1'b0;
    #1;
  endtask

  task automatic cycle(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                       input logic fwe, input logic c, input logic z);
    drive(we, wa, wd, fwe, c, z);
    edge_and_idle();
  endtask

  initial begin
    logic [7:0] exp_pre;

    vecs[0] = '{1'b1, 4'd5,  8'h3C, 1'b0, 1'b1, 1'b1, 4'd5,  4'd5,  8'h3C, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'd9,  8'h7E, 1'b1, 1'b1, 1'b1, 4'd9,  4'd10, 8'h7E, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 4'd9,  8'hAA, 1'b0, 1'b0, 1'b0, 4'd9,  4'd9,  8'h7E, 8'h7E, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 4'd0,  8'hC3, 1'b1, 1'b0, 1'b0, 4'd0,  4'd5,  8'hC3, 8'h3C, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd15, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd15, 4'd0,  8'hFF, 8'hC3, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 4'd5,  8'h01, 1'b0, 1'b0, 1'b1, 4'd5,  4'd9,  8'h01, 8'h7E, 1'b1, 1'b0};

    reset = 1'b1;
    rd_addr_a = '0; rd_addr_b = '0;
    drive(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;

    // Asynchronous reset over non-zero contents
    cycle(1'b1, 4'd3, 8'hA5, 1'b1, 1'b1, 1'b1);
    rd_addr_a = 4'd3; #1;
    chk("pre_reset_reg3", rd_data_a, 8'hA5);
    chk("pre_reset_carry", {7'b0, carry_flag}, 8'h01);
    reset = 1'b1;
    model_clear();
    #1;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i); #1;
      chk("reset_rd_a", rd_data_a, 8'h00);
      chk("reset_rd_b", rd_data_b, 8'h00);
    end
    chk("reset_carry", {7'b0, carry_flag}, 8'h00);
    chk("reset_zero",  {7'b0, zero_flag},  8'h00);
    @(posedge clk); #1 reset = 1'b0; #1;

    // Write then read reg 5: old value before the edge, new after
    rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    drive(1'b1, 4'd5, 8'h3C, 1'b0, 1'b0, 1'b0);
    #1 chk("wr5_pre_edge", rd_data_a, 8'h00);
    edge_and_idle();
    chk("wr5_post_edge", rd_data_a, 8'h3C);

    // Directed vector table (continues from reg5 = 3C, others 0, flags 0)
    for (int v = 0; v < 6; v++) begin
      rd_addr_a = vecs[v].ra; rd_addr_b = vecs[v].rb;
      cycle(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].fwe, vecs[v].c, vecs[v].z);
      chk($sformatf("vec%0d_rd_a", v), rd_data_a, vecs[v].exp_a);
      chk($sformatf("vec%0d_rd_b", v), rd_data_b, vecs[v].exp_b);
      chk($sformatf("vec%0d_carry", v), {7'b0, carry_flag}, {7'b0, vecs[v].exp_c});
      chk($sformatf("vec%0d_zero", v),  {7'b0, zero_flag},  {7'b0, vecs[v].exp_z});
    end

    // Read during write to the same address
    cycle(1'b1, 4'd2, 8'h11, 1'b0, 1'b0, 1'b0);
    rd_addr_b = 4'd2;
    drive(1'b1, 4'd2, 8'h22, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rw_same_pre_edge", rd_data_b, 8'h22);
`else
    chk("rw_same_pre_edge", rd_data_b, 8'h11);
`endif
    edge_and_idle();
    chk("rw_same_post_edge", rd_data_b, 8'h22);

    // Flag set / hold / clear
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("flags_set", {6'b0, carry_flag, zero_flag}, 8'h03);
    cycle(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("flags_hold", {6'b0, carry_flag, zero_flag}, 8'h03);
    cycle(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("flags_clear", {6'b0, carry_flag, zero_flag}, 8'h00);

    // Reset mid-cycle while a write and flag update are pending
    cycle(1'b1, 4'd4, 8'h55, 1'b1, 1'b0, 1'b1);
    rd_addr_a = 4'd4;
    chk("mid_reg4_before", rd_data_a, 8'h55);
    drive(1'b1, 4'd4, 8'h99, 1'b1, 1'b1, 1'b1);
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk("mid_reset_reg4", rd_data_a, 8'h00);
    chk("mid_reset_flags", {6'b0, carry_flag, zero_flag}, 8'h00);
    @(posedge clk); #1;
    chk("mid_reset_held_reg4", rd_data_a, 8'h00);
    chk("mid_reset_held_flags", {6'b0, carry_flag, zero_flag}, 8'h00);
    reset = 1'b0;
    edge_and_idle();
    chk("after_reset_reg4", rd_data_a, 8'h99);
    chk("after_reset_flags", {6'b0, carry_flag, zero_flag}, 8'h03);

    // Randomized cycles against the array model
    for (int n = 0; n < 300; n++) begin
      rd_addr_a = 4'($urandom_range(0, 15));
      rd_addr_b = 4'($urandom_range(0, 15));
      drive(1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      exp_pre = model_mem[rd_addr_a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == rd_addr_a) exp_pre = wr_data;
`endif
      chk("rand_pre_a", rd_data_a, exp_pre);
      exp_pre = model_mem[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr == rd_addr_b) exp_pre = wr_data;
`endif
      chk("rand_pre_b", rd_data_b, exp_pre);
      edge_and_idle();
      chk("rand_post_a", rd_data_a, model_mem[rd_addr_a]);
      chk("rand_post_b", rd_data_b, model_mem[rd_addr_b]);
      chk("rand_flags", {6'b0, carry_flag, zero_flag}, {6'b0, model_c, model_z});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
